// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver: FSM state encoding,
// legal prescale values, parity selection and the prescale legaliser.
package uart_pkg;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE   = 3'd0;
    localparam uart_state_t ST_START  = 3'd1;
    localparam uart_state_t ST_DATA   = 3'd2;
    localparam uart_state_t ST_PARITY = 3'd3;
    localparam uart_state_t ST_STOP   = 3'd4;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Anything other than 16 or 32 runs at 8 cycles per bit.
    function automatic logic [5:0] legal_prescale(input logic [5:0] p);
        case (p)
            PRESCALE_16, PRESCALE_32: return p;
            default:                  return PRESCALE_8;
        endcase
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Signal bundle between a serial line driver/consumer and uart_receiver.
// Handshake: data_valid is a one-cycle push with no ready/backpressure; the
// consumer must take parallel_data in the cycle data_valid is high.
interface uart_receiver_if #(parameter int DATA_WIDTH = 8);

    logic                  RX_in;
    logic [5:0]            prescale;
    logic                  parity_enable;
    logic                  parity_type;
    logic [DATA_WIDTH-1:0] parallel_data;
    logic                  data_valid;
    logic                  parity_error;
    logic                  frame_error;

    modport master (
        output RX_in, prescale, parity_enable, parity_type,
        input  parallel_data, data_valid, parity_error, frame_error
    );

    modport slave (
        input  RX_in, prescale, parity_enable, parity_type,
        output parallel_data, data_valid, parity_error, frame_error
    );

endinterface

// File: rtl/uart_rx_sampler.sv
// Bit-cycle counter and sample-point logic. Define UART_RX_MAJORITY_SAMPLE_EN
// to vote over three samples around mid-bit instead of one.
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       active,
    input  logic [5:0] prescale,
    output logic       bit_end,
    output logic       bit_val
);

    logic [5:0] cycle_cnt;
    logic [5:0] half;

    assign half    = {1'b0, prescale[5:1]};
    assign bit_end = active && (cycle_cnt == prescale - 6'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= 6'd0;
        end else if (!active || bit_end) begin
            cycle_cnt <= 6'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 6'd1;
        end
    end

`ifdef UART_RX_MAJORITY_SAMPLE_EN
    logic [2:0] samp;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            samp <= 3'b000;
        end else if (active) begin
            if (cycle_cnt == half - 6'd1) samp[0] <= rx;
            if (cycle_cnt == half)        samp[1] <= rx;
            if (cycle_cnt == half + 6'd1) samp[2] <= rx;
        end
    end

    // All three samples are settled well before the last count of the bit.
    assign bit_val = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
`else
    logic samp;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            samp <= 1'b0;
        end else if (active && (cycle_cnt == half)) begin
            samp <= rx;
        end
    end

    assign bit_val = samp;
`endif

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: frame FSM, shift register and parity/stop checks.
// Optional UART_RX_MAJORITY_SAMPLE_EN selects 3-sample voting in the sampler.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    uart_receiver_if.slave      rx_if,
    output uart_state_t         state_dbg
);

    localparam int BCW = $clog2(DATA_WIDTH + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

    uart_state_t           state;
    logic [BCW-1:0]        bit_cnt;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [5:0]            presc_q;
    logic                  par_en_q;
    logic                  par_type_q;
    logic                  perr_q;
    logic                  bit_end;
    logic                  bit_val;
    logic                  exp_par;

    assign state_dbg = state;
    assign exp_par   = (par_type_q == PARITY_ODD) ? ~^shift_q : ^shift_q;

    uart_rx_sampler u_sampler (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx_if.RX_in),
        .active   (state != ST_IDLE),
        .prescale (presc_q),
        .bit_end  (bit_end),
        .bit_val  (bit_val)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= ST_IDLE;
            bit_cnt             <= '0;
            shift_q             <= '0;
            presc_q             <= PRESCALE_8;
            par_en_q            <= 1'b0;
            par_type_q          <= PARITY_EVEN;
            perr_q              <= 1'b0;
            rx_if.parallel_data <= '0;
            rx_if.data_valid    <= 1'b0;
            rx_if.parity_error  <= 1'b0;
            rx_if.frame_error   <= 1'b0;
        end else begin
            rx_if.data_valid   <= 1'b0;
            rx_if.parity_error <= 1'b0;
            rx_if.frame_error  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_if.RX_in) begin
                        state      <= ST_START;
                        presc_q    <= legal_prescale(rx_if.prescale);
                        par_en_q   <= rx_if.parity_enable;
                        par_type_q <= rx_if.parity_type;
                        bit_cnt    <= '0;
                        perr_q     <= 1'b0;
                    end
                end
                ST_START: begin
                    // A high mid-start sample is a line glitch, not a frame.
                    if (bit_end) state <= bit_val ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shift_q <= {bit_val, shift_q[DATA_WIDTH-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= par_en_q ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        perr_q <= (bit_val != exp_par);
                        state  <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        rx_if.parity_error <= perr_q;
                        rx_if.frame_error  <= !bit_val;
                        if (!perr_q && bit_val) begin
                            rx_if.data_valid    <= 1'b1;
                            rx_if.parallel_data <= shift_q;
                        end
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: parity, framing, glitch, prescale,
// back-to-back and mid-frame reset scenarios with hand-computed expectations.
module tb_uart_receiver;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    uart_state_t state_dbg;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    uart_receiver_if #(.DATA_WIDTH(8)) rx_bus ();

    uart_receiver #(.DATA_WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_if     (rx_bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Pulse monitor: counts pulses and records each delivered word and its cycle.
    int         dv_cnt = 0, pe_cnt = 0, fe_cnt = 0, both_cnt = 0;
    logic [7:0] got_q[$];
    int         dv_t[$];

    always @(negedge clk) begin
        if (reset) begin
            if (rx_bus.data_valid) begin
                dv_cnt++;
                got_q.push_back(rx_bus.parallel_data);
                dv_t.push_back(cyc);
            end
            if (rx_bus.parity_error) pe_cnt++;
            if (rx_bus.frame_error) fe_cnt++;
            if (rx_bus.parity_error && rx_bus.frame_error) both_cnt++;
        end
    end

    logic [7:0] exp_q[$];

    task automatic send_bit(input logic b, input int p);
        rx_bus.RX_in = b;
        repeat (p) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int p, input logic use_par,
                              input logic par_bit, input logic stop_bit);
        send_bit(1'b0, p);
        for (int i = 0; i < 8; i++) send_bit(d[i], p);
        if (use_par) send_bit(par_bit, p);
        send_bit(stop_bit, p);
        rx_bus.RX_in = 1'b1;
    endtask

    task automatic idle(input int n);
        rx_bus.RX_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cfg(input logic [5:0] p, input logic pe, input logic pt);
        rx_bus.prescale      = p;
        rx_bus.parity_enable = pe;
        rx_bus.parity_type   = pt;
    endtask

    task automatic check_counts(input string name, input int dv0, input int pe0, input int fe0,
                                input int dv_e, input int pe_e, input int fe_e);
        total++;
        if ((dv_cnt - dv0) !== dv_e || (pe_cnt - pe0) !== pe_e || (fe_cnt - fe0) !== fe_e) begin
            bad++;
            $display("FAIL %s pulses: got dv=%0d pe=%0d fe=%0d, need dv=%0d pe=%0d fe=%0d", name,
                     dv_cnt - dv0, pe_cnt - pe0, fe_cnt - fe0, dv_e, pe_e, fe_e);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (state_dbg !== ST_IDLE) begin bad++; $display("FAIL reset_state got %0d need %0d", state_dbg, ST_IDLE); end
        total++;
        if (rx_bus.parallel_data !== 8'h00) begin bad++; $display("FAIL reset_data got %h need 00", rx_bus.parallel_data); end
        total++;
        if ({rx_bus.data_valid, rx_bus.parity_error, rx_bus.frame_error} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got %b need 000", {rx_bus.data_valid, rx_bus.parity_error, rx_bus.frame_error});
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        idle(4);
    endtask

    task automatic test_even_parity();
        int dv0 = dv_cnt, pe0 = pe_cnt, fe0 = fe_cnt, g0 = got_q.size();
        set_cfg(6'd8, 1'b1, PARITY_EVEN);
        send_frame(8'hE6, 8, 1'b1, 1'b1, 1'b1);   // 0xE6 has five ones -> even bit 1
        idle(8);
        check_counts("even_parity", dv0, pe0, fe0, 1, 0, 0);
        exp_q.push_back(8'hE6);
        total++;
        if (got_q.size() != g0 + 1 || got_q[g0] !== exp_q[0]) begin
            bad++; $display("FAIL even_parity_word got %h need %h", (got_q.size() > g0) ? got_q[g0] : 8'hxx, exp_q[0]);
        end
        total++;
        if (rx_bus.parallel_data !== 8'hE6) begin bad++; $display("FAIL even_parity_data got %h need e6", rx_bus.parallel_data); end
        exp_q.delete();
    endtask

    task automatic test_parity_error();
        int dv0 = dv_cnt, pe0 = pe_cnt, fe0 = fe_cnt;
        set_cfg(6'd8, 1'b1, PARITY_ODD);
        send_frame(8'hFF, 8, 1'b1, 1'b0, 1'b1);   // odd parity of 0xFF needs 1
        idle(8);
        check_counts("parity_error", dv0, pe0, fe0, 0, 1, 0);
        total++;
        if (rx_bus.parallel_data !== 8'hE6) begin bad++; $display("FAIL parity_error_hold got %h need e6", rx_bus.parallel_data); end
    endtask

    task automatic test_frame_error();
        int dv0 = dv_cnt, pe0 = pe_cnt, fe0 = fe_cnt;
        set_cfg(6'd8, 1'b0, PARITY_EVEN);
        send_frame(8'hF4, 8, 1'b0, 1'b0, 1'b0);
        idle(8);
        check_counts("frame_error", dv0, pe0, fe0, 0, 0, 1);
        total++;
        if (rx_bus.parallel_data !== 8'hE6) begin bad++; $display("FAIL frame_error_hold got %h need e6", rx_bus.parallel_data); end
    endtask

    task automatic test_both_errors();
        int dv0 = dv_cnt, pe0 = pe_cnt, fe0 = fe_cnt, b0 = both_cnt;
        set_cfg(6'd8, 1'b1, PARITY_EVEN);
        send_frame(8'h0F, 8, 1'b1, 1'b1, 1'b0);   // even bit of 0x0F is 0, send 1; stop 0
        idle(8);
        check_counts("both_errors", dv0, pe0, fe0, 0, 1, 1);
        total++;
        if (both_cnt - b0 !== 1) begin bad++; $display("FAIL both_errors_same_cycle got %0d need 1", both_cnt - b0); end
    endtask

    task automatic test_glitch();
        int dv0 = dv_cnt, pe0 = pe_cnt, fe0 = fe_cnt;
        set_cfg(6'd16, 1'b0, PARITY_EVEN);
        rx_bus.RX_in = 1'b0;
        @(negedge clk);
        total++;
        if (state_dbg !== ST_START) begin bad++; $display("FAIL glitch_start got %0d need %0d", state_dbg, ST_START); end
        repeat (2) @(negedge clk);
        idle(32);
        total++;
        if (state_dbg !== ST_IDLE) begin bad++; $display("FAIL glitch_idle got %0d need %0d", state_dbg, ST_IDLE); end
        check_counts("glitch", dv0, pe0, fe0, 0, 0, 0);
    endtask

    task automatic test_illegal_prescale();
        int dv0 = dv_cnt, pe0 = pe_cnt, fe0 = fe_cnt;
        set_cfg(6'd12, 1'b0, PARITY_EVEN);         // must behave as 8
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
        idle(8);
        check_counts("illegal_prescale", dv0, pe0, fe0, 1, 0, 0);
        total++;
        if (rx_bus.parallel_data !== 8'hA5) begin bad++; $display("FAIL illegal_prescale_data got %h need a5", rx_bus.parallel_data); end
    endtask

    task automatic test_back_to_back();
        int dv0 = dv_cnt, pe0 = pe_cnt, fe0 = fe_cnt, g0 = got_q.size(), t0 = dv_t.size();
        int gap;
        set_cfg(6'd32, 1'b0, PARITY_EVEN);
        send_frame(8'h55, 32, 1'b0, 1'b0, 1'b1);
        send_frame(8'hAA, 32, 1'b0, 1'b0, 1'b1);
        idle(40);
        check_counts("back_to_back", dv0, pe0, fe0, 2, 0, 0);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (got_q.size() <= g0 + i || got_q[g0 + i] !== exp_q[i]) begin
                bad++; $display("FAIL back_to_back_word%0d got %h need %h", i,
                                (got_q.size() > g0 + i) ? got_q[g0 + i] : 8'hxx, exp_q[i]);
            end
        end
        exp_q.delete();
        // 10 bit-times of 32 cycles, plus the cycle spent re-arming in IDLE.
        gap = (dv_t.size() >= t0 + 2) ? dv_t[t0 + 1] - dv_t[t0] : -1;
        total++;
        if (gap < 320 || gap > 322) begin bad++; $display("FAIL back_to_back_gap got %0d need 320..322", gap); end
    endtask

    task automatic test_reset_mid_frame();
        int dv0 = dv_cnt, pe0 = pe_cnt, fe0 = fe_cnt;
        set_cfg(6'd8, 1'b0, PARITY_EVEN);
        send_bit(1'b0, 8);
        send_bit(1'b0, 8);
        send_bit(1'b0, 8);
        send_bit(1'b1, 4);
        reset = 1'b0;
        rx_bus.RX_in = 1'b1;
        @(negedge clk);
        total++;
        if (state_dbg !== ST_IDLE) begin bad++; $display("FAIL midreset_state got %0d need %0d", state_dbg, ST_IDLE); end
        total++;
        if ({rx_bus.parallel_data, rx_bus.data_valid, rx_bus.parity_error, rx_bus.frame_error} !== 11'd0) begin
            bad++; $display("FAIL midreset_outputs got data=%h flags=%b need 00/000", rx_bus.parallel_data,
                            {rx_bus.data_valid, rx_bus.parity_error, rx_bus.frame_error});
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        idle(4);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
        idle(8);
        check_counts("midreset_recover", dv0, pe0, fe0, 1, 0, 0);
        total++;
        if (rx_bus.parallel_data !== 8'h3C) begin bad++; $display("FAIL midreset_data got %h need 3c", rx_bus.parallel_data); end
    endtask

    initial begin
        rx_bus.RX_in = 1'b1;
        set_cfg(6'd8, 1'b0, PARITY_EVEN);
        test_reset();
        test_even_parity();
        test_parity_error();
        test_frame_error();
        test_both_errors();
        test_glitch();
        test_illegal_prescale();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
